// File: rtl/memory_unit_if.sv
// ----------------------------------------------------------------------------
// memory_unit_if
//   Shared single-port memory bus between the memory_unit sequencer (master)
//   and the memory / bus fabric (slave).
//
//   bus_req      master -> slave  transaction request, held until acked
//   bus_we       master -> slave  1 = write, 0 = read
//   bus_addr     master -> slave  word-aligned byte address
//   bus_sel      master -> slave  byte lane select
//   bus_wr_data  master -> slave  write data
//   bus_rd_data  slave  -> master read data, valid while bus_ack = 1
//   bus_ack      slave  -> master completion, sampled only while bus_req = 1
// ----------------------------------------------------------------------------
interface memory_unit_if #(
    parameter int DATA_SIZE = 32
);
    logic                     bus_req;
    logic                     bus_we;
    logic [DATA_SIZE-1:0]     bus_addr;
    logic [DATA_SIZE/8-1:0]   bus_sel;
    logic [DATA_SIZE-1:0]     bus_wr_data;
    logic [DATA_SIZE-1:0]     bus_rd_data;
    logic                     bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wr_data,
        input  bus_rd_data, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wr_data,
        output bus_rd_data, bus_ack
    );
endinterface

// File: rtl/memory_unit.sv
// ----------------------------------------------------------------------------
// memory_unit
//   Sequences one optional data access (load/store) followed by one
//   instruction fetch per pipeline step over a single shared memory bus,
//   holding the pipeline with mem_busy until both accesses have finished.
//   Accesses that are not acknowledged within TIMEOUT cycles are aborted and
//   reported through a one-cycle access_fault pulse.
//
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   inst_mem_addr  in   fetch address (PC)
//   inst           out  fetched instruction word
//   data_mem_addr  in   load/store address
//   wr_data        in   store data
//   mem_rd_en      in   load request this step
//   mem_wr_en      in   store request this step (wins over mem_rd_en)
//   mem_byte_en    in   byte lane enables of the load/store
//   rd_data        out  raw bus word of the last load
//   mem_busy       out  1 = pipeline must hold
//   access_fault   out  one-cycle pulse in DONE when an access timed out
//   bus            master side of memory_unit_if (all outputs registered)
// ----------------------------------------------------------------------------
module memory_unit #(
    parameter int DATA_SIZE = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_SIZE-1:0]   inst_mem_addr,
    output logic [31:0]            inst,
    input  logic [DATA_SIZE-1:0]   data_mem_addr,
    input  logic [DATA_SIZE-1:0]   wr_data,
    input  logic                   mem_rd_en,
    input  logic                   mem_wr_en,
    input  logic [DATA_SIZE/8-1:0] mem_byte_en,
    output logic [DATA_SIZE-1:0]   rd_data,
    output logic                   mem_busy,
    output logic                   access_fault,
    memory_unit_if.master          bus
);
    localparam int SEL_W      = DATA_SIZE / 8;
    localparam int ALIGN_BITS = $clog2(SEL_W);
    localparam logic [DATA_SIZE-1:0] ALIGN_MASK =
        ~((DATA_SIZE'(1) << ALIGN_BITS) - DATA_SIZE'(1));
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DONE} state_t;

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DATA_SIZE-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [DATA_SIZE-1:0] wdata_q, wdata_d;
    logic [31:0]          inst_q, inst_d;
    logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
    logic                 fault_q, fault_d;          // some access of this step timed out
    logic                 access_fault_q, access_fault_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] inst_addr_q, inst_addr_d;  // PC captured in IDLE
    logic [31:0]          fetch_word;
    logic                 expired;

    // On a 64-bit bus the instruction sits in the half selected by PC bit 2.
    always_comb begin
        if (DATA_SIZE == 64 && inst_addr_q[2]) begin
            fetch_word = 32'(bus.bus_rd_data >> 32);
        end else begin
            fetch_word = bus.bus_rd_data[31:0];
        end
    end

    // This edge is the last permitted wait cycle of the current access.
    assign expired = (cnt_q == CNT_LAST);

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        sel_d          = sel_q;
        wdata_d        = wdata_q;
        inst_d         = inst_q;
        rd_data_d      = rd_data_q;
        fault_d        = fault_q;
        access_fault_d = 1'b0;
        cnt_d          = cnt_q;
        inst_addr_d    = inst_addr_q;

        case (state_q)
            IDLE: begin
                inst_addr_d = inst_mem_addr;
                fault_d     = 1'b0;
                cnt_d       = '0;
                req_d       = 1'b1;
                if (mem_wr_en || mem_rd_en) begin
                    state_d = DATA;
                    addr_d  = data_mem_addr & ALIGN_MASK;
                    we_d    = mem_wr_en;
                    sel_d   = mem_byte_en;
                    wdata_d = wr_data;
                end else begin
                    state_d = FETCH;
                    addr_d  = inst_mem_addr & ALIGN_MASK;
                    we_d    = 1'b0;
                    sel_d   = '1;
                end
            end

            DATA: begin
                if (bus.bus_ack || expired) begin
                    // A timed-out load keeps the previous rd_data.
                    if (bus.bus_ack && !we_q) rd_data_d = bus.bus_rd_data;
                    if (!bus.bus_ack)         fault_d   = 1'b1;
                    // Fetch request follows back-to-back; bus_req stays high.
                    state_d = FETCH;
                    cnt_d   = '0;
                    addr_d  = inst_addr_q & ALIGN_MASK;
                    we_d    = 1'b0;
                    sel_d   = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FETCH: begin
                if (bus.bus_ack || expired) begin
                    inst_d         = bus.bus_ack ? fetch_word : NOP_INST;
                    req_d          = 1'b0;
                    access_fault_d = fault_q || !bus.bus_ack;
                    state_d        = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            sel_q          <= '0;
            wdata_q        <= '0;
            inst_q         <= '0;
            rd_data_q      <= '0;
            fault_q        <= 1'b0;
            access_fault_q <= 1'b0;
            cnt_q          <= '0;
            inst_addr_q    <= '0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            sel_q          <= sel_d;
            wdata_q        <= wdata_d;
            inst_q         <= inst_d;
            rd_data_q      <= rd_data_d;
            fault_q        <= fault_d;
            access_fault_q <= access_fault_d;
            cnt_q          <= cnt_d;
            inst_addr_q    <= inst_addr_d;
        end
    end

    assign bus.bus_req     = req_q;
    assign bus.bus_we      = we_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_sel     = sel_q;
    assign bus.bus_wr_data = wdata_q;
    assign inst            = inst_q;
    assign rd_data         = rd_data_q;
    assign access_fault    = access_fault_q;
    assign mem_busy        = (state_q != DONE);
endmodule

// File: tb/tb_memory_unit.sv
// ----------------------------------------------------------------------------
// tb_memory_unit
//   Directed bench for memory_unit (DATA_SIZE=32, TIMEOUT=6). The bench plays
//   the memory side of the bus itself, cycle by cycle, and compares outputs
//   1 time unit after each rising edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_memory_unit;
    localparam int DS = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [DS-1:0] inst_mem_addr = '0;
    logic [31:0]   inst;
    logic [DS-1:0] data_mem_addr = '0;
    logic [DS-1:0] wr_data = '0;
    logic          mem_rd_en = 1'b0;
    logic          mem_wr_en = 1'b0;
    logic [3:0]    mem_byte_en = '0;
    logic [DS-1:0] rd_data;
    logic          mem_busy;
    logic          access_fault;

    int checks = 0;
    int passed = 0;

    memory_unit_if #(.DATA_SIZE(DS)) bus_if ();

    memory_unit #(.DATA_SIZE(DS), .TIMEOUT(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .inst_mem_addr (inst_mem_addr),
        .inst          (inst),
        .data_mem_addr (data_mem_addr),
        .wr_data       (wr_data),
        .mem_rd_en     (mem_rd_en),
        .mem_wr_en     (mem_wr_en),
        .mem_byte_en   (mem_byte_en),
        .rd_data       (rd_data),
        .mem_busy      (mem_busy),
        .access_fault  (access_fault),
        .bus           (bus_if.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full snapshot of the registered bus request.
    task automatic check_bus(input string tag, input logic req, input logic we,
                             input logic [31:0] addr, input logic [3:0] sel);
        check({tag, ".req"},  bus_if.bus_req, req);
        check({tag, ".we"},   bus_if.bus_we,  we);
        check({tag, ".addr"}, bus_if.bus_addr, addr);
        check({tag, ".sel"},  bus_if.bus_sel, sel);
    endtask

    initial begin
        bus_if.bus_ack     = 1'b1;
        bus_if.bus_rd_data = 32'h0000_AAAA;
        inst_mem_addr      = 32'h100;

        // ---- reset state ----
        tick();
        tick();
        check_bus("rst", 1'b0, 1'b0, 32'h0, 4'h0);
        check("rst.wdata", bus_if.bus_wr_data, 32'h0);
        check("rst.inst", inst, 32'h0);
        check("rst.rd_data", rd_data, 32'h0);
        check("rst.fault", access_fault, 1'b0);
        check("rst.busy", mem_busy, 1'b1);
        reset = 1'b0;

        // ---- 1: fetch-only steps, ack always high ----
        tick();  // IDLE -> FETCH
        check_bus("t1.fetch", 1'b1, 1'b0, 32'h100, 4'hF);
        check("t1.busy1", mem_busy, 1'b1);
        tick();  // FETCH -> DONE
        check("t1.busy2", mem_busy, 1'b0);
        check("t1.req_done", bus_if.bus_req, 1'b0);
        check("t1.inst", inst, 32'h0000_AAAA);
        bus_if.bus_rd_data = 32'h1111_2222;
        tick();  // IDLE
        check("t1.busy3", mem_busy, 1'b1);
        check("t1.req_idle", bus_if.bus_req, 1'b0);
        tick();  // FETCH
        check("t1.req2", bus_if.bus_req, 1'b1);
        tick();  // DONE
        check("t1.busy5", mem_busy, 1'b0);
        check("t1.inst2", inst, 32'h1111_2222);

        // ---- 2: load, zero-wait ----
        mem_rd_en          = 1'b1;
        data_mem_addr      = 32'h2002;
        mem_byte_en        = 4'h4;
        inst_mem_addr      = 32'h104;
        bus_if.bus_rd_data = 32'hAABB_CCDD;
        tick();  // IDLE
        check("t2.busy_idle", mem_busy, 1'b1);
        tick();  // DATA
        check_bus("t2.data", 1'b1, 1'b0, 32'h2000, 4'h4);
        tick();  // FETCH
        check("t2.rd_data", rd_data, 32'hAABB_CCDD);
        check_bus("t2.fetch", 1'b1, 1'b0, 32'h104, 4'hF);
        check("t2.busy_fetch", mem_busy, 1'b1);
        mem_rd_en          = 1'b0;
        bus_if.bus_rd_data = 32'h0050_0093;
        tick();  // DONE
        check("t2.busy_done", mem_busy, 1'b0);
        check("t2.inst", inst, 32'h0050_0093);

        // ---- 3: store with delayed ack ----
        mem_wr_en      = 1'b1;
        wr_data        = 32'h1234_5678;
        mem_byte_en    = 4'hF;
        data_mem_addr  = 32'h3000;
        bus_if.bus_ack = 1'b0;
        tick();  // IDLE
        tick();  // DATA, wait cycle 1
        check_bus("t3.data", 1'b1, 1'b1, 32'h3000, 4'hF);
        check("t3.wdata", bus_if.bus_wr_data, 32'h1234_5678);
        // Inputs wiggle while waiting; the request must not follow them.
        data_mem_addr = 32'hDEAD_0000;
        wr_data       = 32'h0;
        mem_byte_en   = 4'h1;
        for (int i = 0; i < 4; i++) begin
            tick();  // wait cycles 2..5
            check_bus("t3.hold", 1'b1, 1'b1, 32'h3000, 4'hF);
            check("t3.hold.wdata", bus_if.bus_wr_data, 32'h1234_5678);
            check("t3.hold.busy", mem_busy, 1'b1);
        end
        bus_if.bus_ack     = 1'b1;
        bus_if.bus_rd_data = 32'hCAFE_F00D;
        mem_wr_en          = 1'b0;
        tick();  // DATA acked -> FETCH
        check("t3.rd_data", rd_data, 32'hAABB_CCDD);
        check_bus("t3.fetch", 1'b1, 1'b0, 32'h104, 4'hF);
        tick();  // DONE
        check("t3.inst", inst, 32'hCAFE_F00D);
        check("t3.busy_done", mem_busy, 1'b0);
        check("t3.fault", access_fault, 1'b0);

        // ---- 4: fetch never acked -> timeout after 6 wait cycles ----
        bus_if.bus_ack = 1'b0;
        inst_mem_addr  = 32'h200;
        tick();  // IDLE
        tick();  // FETCH, wait cycle 1
        check_bus("t4.fetch", 1'b1, 1'b0, 32'h200, 4'hF);
        for (int i = 0; i < 5; i++) begin
            tick();  // wait cycles 2..6
            check("t4.wait.req", bus_if.bus_req, 1'b1);
            check("t4.wait.busy", mem_busy, 1'b1);
        end
        tick();  // abort -> DONE
        check("t4.req", bus_if.bus_req, 1'b0);
        check("t4.inst", inst, 32'h0000_0013);
        check("t4.fault", access_fault, 1'b1);
        check("t4.busy", mem_busy, 1'b0);
        // Stray ack while no request is pending.
        bus_if.bus_ack     = 1'b1;
        bus_if.bus_rd_data = 32'h9999_9999;
        tick();  // IDLE
        check("t4.fault_clr", access_fault, 1'b0);
        check("t4.stray.req", bus_if.bus_req, 1'b0);
        check("t4.stray.inst", inst, 32'h0000_0013);
        check("t4.stray.busy", mem_busy, 1'b1);

        // ---- 6: rd_en and wr_en together -> single write ----
        mem_rd_en     = 1'b1;
        mem_wr_en     = 1'b1;
        data_mem_addr = 32'h4007;
        wr_data       = 32'h55AA_55AA;
        mem_byte_en   = 4'h3;
        inst_mem_addr = 32'h300;
        tick();  // DATA
        check_bus("t6.data", 1'b1, 1'b1, 32'h4004, 4'h3);
        check("t6.wdata", bus_if.bus_wr_data, 32'h55AA_55AA);
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        tick();  // FETCH
        check("t6.rd_data", rd_data, 32'hAABB_CCDD);
        check_bus("t6.fetch", 1'b1, 1'b0, 32'h300, 4'hF);
        tick();  // DONE
        check("t6.inst", inst, 32'h9999_9999);
        check("t6.fault", access_fault, 1'b0);

        // ---- 5: reset while DATA is waiting ----
        mem_rd_en      = 1'b1;
        data_mem_addr  = 32'h5000;
        mem_byte_en    = 4'hF;
        bus_if.bus_ack = 1'b0;
        tick();  // IDLE
        tick();  // DATA
        check("t5.req_pre", bus_if.bus_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_bus("t5.rst", 1'b0, 1'b0, 32'h0, 4'h0);
        check("t5.rst.wdata", bus_if.bus_wr_data, 32'h0);
        check("t5.rst.inst", inst, 32'h0);
        check("t5.rst.rd_data", rd_data, 32'h0);
        check("t5.rst.busy", mem_busy, 1'b1);
        mem_rd_en          = 1'b0;
        inst_mem_addr      = 32'h100;
        bus_if.bus_ack     = 1'b1;
        bus_if.bus_rd_data = 32'h0000_0077;
        tick();
        reset = 1'b0;
        tick();  // IDLE -> FETCH (data access not resumed)
        check_bus("t5.restart", 1'b1, 1'b0, 32'h100, 4'hF);
        tick();  // DONE
        check("t5.inst", inst, 32'h0000_0077);
        check("t5.busy", mem_busy, 1'b0);
        check("t5.rd_data", rd_data, 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
